// File: rtl/tt_serial_sub_pkg.sv
// rtl/tt_serial_sub_pkg.sv - shared types and constants for the bit-serial subtractor tile
package tt_serial_sub_pkg;

   localparam int WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // uio_in strobe positions
   localparam int UIO_LOAD_A = 0;
   localparam int UIO_LOAD_B = 1;
   localparam int UIO_START  = 2;

   // uio_out status positions
   localparam int UIO_BUSY   = 3;
   localparam int UIO_DONE   = 4;
   localparam int UIO_BORROW = 5;

   // Only the three status pins are driven outward
   localparam logic [7:0] UIO_OE = 8'b0011_1000;

endpackage

// File: rtl/tt_um_serial_subtractor_if.sv
// rtl/tt_um_serial_subtractor_if.sv - tile pin bundle with driver/tile views
interface tt_um_serial_subtractor_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (
      output ena, ui_in, uio_in,
      input  uo_out, uio_out, uio_oe
   );

   modport slave (
      input  ena, ui_in, uio_in,
      output uo_out, uio_out, uio_oe
   );
endinterface

// File: rtl/full_subtractor_bit.sv
// rtl/full_subtractor_bit.sv - one-bit full subtractor from two half subtractors
module full_subtractor_bit (
   input  logic i_a,
   input  logic i_b,
   input  logic i_bin,
   output logic o_d,
   output logic o_bout
);
   logic w_d1;
   logic w_b1;
   logic w_b2;

   // First stage: a - b
   half_subtractor u_hs_ab (
      .i_x (i_a),
      .i_y (i_b),
      .o_d (w_d1),
      .o_b (w_b1)
   );

   // Second stage: (a - b) - borrow_in
   half_subtractor u_hs_bin (
      .i_x (w_d1),
      .i_y (i_bin),
      .o_d (o_d),
      .o_b (w_b2)
   );

   // Either stage may generate the outgoing borrow, never both
   always_comb begin
      o_bout = w_b1 | w_b2;
   end
endmodule

// File: rtl/half_subtractor.sv
// rtl/half_subtractor.sv - one-bit half subtractor cell (x - y)
module half_subtractor (
   input  logic i_x,
   input  logic i_y,
   output logic o_d,
   output logic o_b
);
   // Difference is the XOR; a borrow is needed only for 0 - 1
   always_comb begin
      o_d = i_x ^ i_y;
      o_b = ~i_x & i_y;
   end
endmodule

// File: rtl/tt_um_serial_subtractor.sv
// rtl/tt_um_serial_subtractor.sv - bit-serial A-B tile, LSB first, one bit per enabled clock
module tt_um_serial_subtractor #(
   parameter int WIDTH = tt_serial_sub_pkg::WIDTH
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);
   import tt_serial_sub_pkg::*;

   state_t           r_state;
   logic [2:0]       r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_pd;
   logic [WIDTH-1:0] r_res;
   logic             r_br;
   logic             r_borrow;

   logic             w_d;
   logic             w_bout;
   logic             w_load_a;
   logic             w_load_b;
   logic             w_start;
   logic             w_unused_uio;

   assign w_load_a     = uio_in[UIO_LOAD_A];
   assign w_load_b     = uio_in[UIO_LOAD_B];
   assign w_start      = uio_in[UIO_START];
   assign w_unused_uio = &{1'b0, uio_in[7:3]};

   // Single bit cell fed by the operand LSBs and the borrow flip-flop
   full_subtractor_bit u_fsub (
      .i_a    (r_sa[0]),
      .i_b    (r_sb[0]),
      .i_bin  (r_br),
      .o_d    (w_d),
      .o_bout (w_bout)
   );

   // Control FSM plus operand, shift, counter and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 3'd0;
         r_a      <= '0;
         r_b      <= '0;
         r_sa     <= '0;
         r_sb     <= '0;
         r_pd     <= '0;
         r_res    <= '0;
         r_br     <= 1'b0;
         r_borrow <= 1'b0;
      end else if (ena) begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_start) begin
                  // Start wins over loads: the launch uses the operands already held
                  r_sa    <= r_a;
                  r_sb    <= r_b;
                  r_pd    <= '0;
                  r_br    <= 1'b0;
                  r_cnt   <= 3'd0;
                  r_state <= ST_RUN;
               end else begin
                  if (w_load_a) r_a <= ui_in[WIDTH-1:0];
                  if (w_load_b) r_b <= ui_in[WIDTH-1:0];
               end
            end
            ST_RUN: begin
               r_pd  <= {w_d, r_pd[WIDTH-1:1]};
               r_sa  <= r_sa >> 1;
               r_sb  <= r_sb >> 1;
               r_br  <= w_bout;
               r_cnt <= r_cnt + 3'd1;
               if (r_cnt == 3'(WIDTH - 1)) begin
                  // Last bit: publish the completed difference and final borrow
                  r_res    <= {w_d, r_pd[WIDTH-1:1]};
                  r_borrow <= w_bout;
                  r_state  <= ST_DONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Status pins are pure decodes of registered state
   always_comb begin
      uo_out              = r_res;
      uio_out             = 8'h00;
      uio_out[UIO_BUSY]   = (r_state == ST_RUN);
      uio_out[UIO_DONE]   = (r_state == ST_DONE);
      uio_out[UIO_BORROW] = r_borrow;
      uio_oe              = UIO_OE;
   end
endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// tb/tb_tt_um_serial_subtractor.sv - scoreboard bench for the serial subtractor tile
module tb_tt_um_serial_subtractor;
   import tt_serial_sub_pkg::*;

   logic clk;
   logic rst_n;

   tt_um_serial_subtractor_if bus ();

   tt_um_serial_subtractor dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (bus.ena),
      .ui_in   (bus.ui_in),
      .uio_in  (bus.uio_in),
      .uo_out  (bus.uo_out),
      .uio_out (bus.uio_out),
      .uio_oe  (bus.uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] diff;
      logic       br;
      int         blen;
   } exp_t;

   exp_t       sb[$];
   int         vectors = 0;
   int         errors  = 0;
   logic [7:0] m_a = 8'h00;
   logic [7:0] m_b = 8'h00;
   int         run_len = 0;

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, req);
      end
   endtask

   // One clock of stimulus, inputs settle 1 time unit after the edge
   task automatic cyc(input logic la, input logic lb, input logic st,
                      input logic [7:0] d, input logic en);
      bus.ena    = en;
      bus.ui_in  = d;
      bus.uio_in = {5'b0, st, lb, la};
      @(posedge clk);
      #1;
   endtask

   task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
      cyc(1'b1, 1'b0, 1'b0, a, 1'b1);
      m_a = a;
      cyc(1'b0, 1'b1, 1'b0, b, 1'b1);
      m_b = b;
   endtask

   // Launch one subtraction and wait for done; the monitor does the result checking
   task automatic run_op(input logic la_with_start, input logic [7:0] la_data,
                         input int load_at, input int off_at, input int off_len);
      exp_t e;
      logic ok;
      logic en;
      e.diff = m_a - m_b;
      e.br   = (m_a < m_b);
      e.blen = 8 + off_len;
      sb.push_back(e);
      cyc(la_with_start, 1'b0, 1'b1, la_data, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         en = !(i >= off_at && i < off_at + off_len);
         cyc(i == load_at, 1'b0, 1'b0, 8'h00, en);
         if (bus.uio_out[UIO_DONE]) begin
            ok = 1'b1;
            break;
         end
      end
      vectors++;
      if (!ok) begin
         errors++;
         $display("FAIL done_timeout: got done=0 expected done=1 within 60 cycles");
      end
   endtask

   // Monitor: measures the busy window and checks each completed result
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         run_len = 0;
      end else if (bus.uio_out[UIO_BUSY]) begin
         run_len++;
      end else if (bus.uio_out[UIO_DONE] && run_len > 0) begin
         vectors++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got result 0x%02h expected no result", bus.uo_out);
         end else begin
            e = sb.pop_front();
            check8("diff", bus.uo_out, e.diff);
            check8("borrow", {7'b0, bus.uio_out[UIO_BORROW]}, {7'b0, e.br});
            check8("busy_cycles", 8'(run_len), 8'(e.blen));
         end
         run_len = 0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before 2ms");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      int         sel;

      rst_n      = 1'b0;
      bus.ena    = 1'b0;
      bus.ui_in  = 8'h00;
      bus.uio_in = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check8("reset_uo_out", bus.uo_out, 8'h00);
      check8("reset_uio_out", bus.uio_out, 8'h00);
      check8("reset_uio_oe", bus.uio_oe, 8'h38);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed cases
      load_ab(8'h5A, 8'h23); run_op(1'b0, 8'h00, -1, 0, 0);
      load_ab(8'h10, 8'h20); run_op(1'b0, 8'h00, -1, 0, 0);
      load_ab(8'h00, 8'h01); run_op(1'b0, 8'h00, -1, 0, 0);
      load_ab(8'hFF, 8'hFF); run_op(1'b0, 8'h00, -1, 0, 0);

      // Load pulse mid-RUN is ignored, and a_reg survives into the next start
      load_ab(8'h5A, 8'h23); run_op(1'b0, 8'h00, 3, 0, 0);
      run_op(1'b0, 8'h00, -1, 0, 0);

      // Start with a simultaneous load uses the old a_reg; repeat proves a_reg kept
      load_ab(8'h40, 8'h01); repeat (2) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      run_op(1'b1, 8'h99, -1, 0, 0);
      run_op(1'b0, 8'h00, -1, 0, 0);

      // Asynchronous reset in the middle of a run
      cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
      repeat (4) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      check8("busy_before_reset", {7'b0, bus.uio_out[UIO_BUSY]}, 8'h01);
      #2;
      rst_n = 1'b0;
      #1;
      check8("midrun_reset_uo_out", bus.uo_out, 8'h00);
      check8("midrun_reset_uio_out", bus.uio_out, 8'h00);
      check8("midrun_reset_uio_oe", bus.uio_oe, 8'h38);
      sb.delete();
      m_a = 8'h00;
      m_b = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      check8("idle_after_reset", bus.uio_out, 8'h00);
      load_ab(8'h5A, 8'h23); run_op(1'b0, 8'h00, -1, 0, 0);

      // ena dropped for three cycles mid-run
      load_ab(8'h10, 8'h20); run_op(1'b0, 8'h00, -1, 2, 3);

      // Randomized operands, reload patterns, idle gaps and enable drops
      for (int n = 0; n < 40; n++) begin
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         sel = int'($urandom_range(0, 3));
         if (sel == 0) begin
            load_ab(ra, rb);
         end else if (sel == 1) begin
            cyc(1'b1, 1'b1, 1'b0, ra, 1'b1);
            m_a = ra;
            m_b = ra;
         end else if (sel == 2) begin
            cyc(1'b0, 1'b1, 1'b0, rb, 1'b1);
            m_b = rb;
         end
         if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
         if ($urandom_range(0, 2) == 0)
            run_op(1'b0, 8'h00, -1, int'($urandom_range(0, 7)), int'($urandom_range(1, 4)));
         else
            run_op(1'b0, 8'h00, -1, 0, 0);
      end

      repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      check8("scoreboard_drained", 8'(sb.size()), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
